// File: rtl/reglist_sequencer.sv
// ---------------------------------------------------------------------------
// reglist_sequencer
//
// Walks the 16-bit register list of an LDM/STM instruction and presents one
// register index per cycle to the load/store unit, lowest-first (ascending)
// or highest-first (descending). Each beat that is accepted (i_stall=0)
// clears its bit from the remaining-mask register. The sequence ends when
// the final bit has been accepted.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          start request, sampled only while o_busy=0
//   i_reglist        register list, bit n = transfer register n
//   i_order          1 = ascending, 0 = descending
//   i_stall          1 = hold the current beat
//   o_busy           sequence in progress (RUN or DONE)
//   o_valid          o_index/o_first/o_last/o_offset are valid
//   o_index          current register index
//   o_first/o_last   current beat is the first/final one
//   o_offset         beats already accepted * WORD_BYTES
//   o_count          popcount of the latched list, held until next start
//   o_done           one-cycle pulse after the sequence ends
//   o_dbg_state      FSM state, for checkers (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a beat is presented whenever o_valid=1 and is consumed on the
// rising edge where i_stall=0; while i_stall=1 every output is held.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// one_detector
//
// Combinational priority picker over a 16-bit mask.
//   mask    bits still to transfer
//   order   1 = report the lowest set bit, 0 = report the highest set bit
//   index   position of the selected bit (0 when mask is empty)
//   single  exactly one bit of mask is set
// ---------------------------------------------------------------------------
module one_detector (
    input  logic [15:0] mask,
    input  logic        order,
    output logic [3:0]  index,
    output logic        single
);

    always_comb begin
        index = 4'd0;
        if (order) begin
            // Scan high to low so the last match is the lowest set bit.
            for (int i = 15; i >= 0; i--) begin
                if (mask[i]) index = 4'(i);
            end
        end else begin
            // Scan low to high so the last match is the highest set bit.
            for (int i = 0; i < 16; i++) begin
                if (mask[i]) index = 4'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only for a one-hot mask.
    assign single = (mask != 16'd0) && ((mask & (mask - 16'd1)) == 16'd0);

endmodule

module reglist_sequencer #(
    parameter int WORD_BYTES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_reglist,
    input  logic        i_order,
    input  logic        i_stall,
    output logic        o_busy,
    output logic        o_valid,
    output logic [3:0]  o_index,
    output logic        o_first,
    output logic        o_last,
    output logic [6:0]  o_offset,
    output logic [4:0]  o_count,
    output logic        o_done,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q,  state_d;
    logic [15:0] mask_q,   mask_d;
    logic        order_q,  order_d;
    logic [6:0]  offset_q, offset_d;
    logic [4:0]  count_q,  count_d;
    logic        first_q,  first_d;

    logic [3:0]  det_index;
    logic        det_single;
    logic        in_run;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    // The detector only sees registered state, so o_index and o_last have
    // no combinational path from any input.
    one_detector u_one_detector (
        .mask   (mask_q),
        .order  (order_q),
        .index  (det_index),
        .single (det_single)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            mask_q   <= 16'd0;
            order_q  <= 1'b0;
            offset_q <= 7'd0;
            count_q  <= 5'd0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            order_q  <= order_d;
            offset_q <= offset_d;
            count_q  <= count_d;
            first_q  <= first_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath updates
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        order_d  = order_q;
        offset_d = offset_q;
        count_d  = count_q;
        first_d  = first_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mask_d   = i_reglist;
                    order_d  = i_order;
                    count_d  = popcount16(i_reglist);
                    offset_d = 7'd0;
                    first_d  = 1'b1;
                    // An empty list has no beats and goes straight to the
                    // completion pulse.
                    state_d  = (i_reglist != 16'd0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (!i_stall) begin
                    mask_d   = mask_q & ~(16'd1 << det_index);
                    offset_d = offset_q + 7'(WORD_BYTES);
                    first_d  = 1'b0;
                    if (det_single) state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Start requests are not looked at here; IDLE is entered
                // unconditionally so back-to-back starts land one cycle on.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: beat fields are forced to zero outside RUN so that idle and
    // reset present an all-zero bus.
    // -----------------------------------------------------------------------
    assign in_run      = (state_q == S_RUN);
    assign o_busy      = (state_q != S_IDLE);
    assign o_valid     = in_run;
    assign o_index     = in_run ? det_index : 4'd0;
    assign o_first     = in_run & first_q;
    assign o_last      = in_run & det_single;
    assign o_offset    = in_run ? offset_q : 7'd0;
    assign o_count     = count_q;
    assign o_done      = (state_q == S_DONE);
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_reglist_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reglist_sequencer
//
// Drives directed and random register lists into reglist_sequencer and
// compares every presented beat against a queue of expected register
// indices built straight from the list bits. Inputs change and outputs are
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_reglist_sequencer;

  localparam int WB = 4;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [15:0] i_reglist;
  logic        i_order;
  logic        i_stall;
  logic        o_busy;
  logic        o_valid;
  logic [3:0]  o_index;
  logic        o_first;
  logic        o_last;
  logic [6:0]  o_offset;
  logic [4:0]  o_count;
  logic        o_done;
  logic [1:0]  o_dbg_state;

  int checks;
  int errors;

  reglist_sequencer #(.WORD_BYTES(WB)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (i_start),
    .i_reglist   (i_reglist),
    .i_order     (i_order),
    .i_stall     (i_stall),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_index     (o_index),
    .o_first     (o_first),
    .o_last      (o_last),
    .o_offset    (o_offset),
    .o_count     (o_count),
    .o_done      (o_done),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------- reset driver
  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    i_start   = 1'b0;
    i_stall   = 1'b0;
    i_reglist = 16'd0;
    i_order   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ------------------------------------------------------ all-zero outputs
  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(o_busy),   0);
    check({tag, "_valid"},  32'(o_valid),  0);
    check({tag, "_index"},  32'(o_index),  0);
    check({tag, "_offset"}, 32'(o_offset), 0);
    check({tag, "_count"},  32'(o_count),  0);
    check({tag, "_done"},   32'(o_done),   0);
  endtask

  // -----------------------------------------------------------------------
  // Run one complete sequence.
  //   mode 0: never stall
  //   mode 1: random stalls
  //   mode 2: stall the first beat for 3 cycles
  //   mode 3: no stalls, pulse i_start with another list mid-sequence
  // -----------------------------------------------------------------------
  task automatic run_seq(input string tag, input logic [15:0] list, input logic order, input int mode);
    logic [3:0] exp_q[$];
    int         accepted;
    int         stall_left;
    int         pc;
    bit         done_seen;
    logic       stall;

    // Reference: the register order is just the set bits of the list read
    // from the low end or the high end.
    exp_q.delete();
    if (order) begin
      for (int i = 0; i < 16; i++) if (list[i]) exp_q.push_back(4'(i));
    end else begin
      for (int i = 15; i >= 0; i--) if (list[i]) exp_q.push_back(4'(i));
    end
    pc = exp_q.size();

    @(negedge clk);
    i_start   = 1'b1;
    i_reglist = list;
    i_order   = order;
    i_stall   = 1'b0;
    @(negedge clk);
    i_start   = 1'b0;
    i_reglist = 16'($urandom);
    i_order   = 1'($urandom);

    accepted   = 0;
    stall_left = (mode == 2) ? 3 : 0;
    done_seen  = 1'b0;

    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      i_start = 1'b0;
      if (o_done) begin
        check({tag, "_done_remaining"}, 32'(exp_q.size()), 0);
        check({tag, "_done_accepted"},  32'(accepted),     32'(pc));
        check({tag, "_done_busy"},      32'(o_busy),       1);
        check({tag, "_done_valid"},     32'(o_valid),      0);
        check({tag, "_done_count"},     32'(o_count),      32'(pc));
        done_seen = 1'b1;
      end else begin
        check({tag, "_valid"}, 32'(o_valid), 1);
        check({tag, "_busy"},  32'(o_busy),  1);
        if (exp_q.size() > 0) begin
          check({tag, "_index"},  32'(o_index),  32'(exp_q[0]));
          check({tag, "_offset"}, 32'(o_offset), 32'(accepted * WB));
          check({tag, "_first"},  32'(o_first),  32'(accepted == 0));
          check({tag, "_last"},   32'(o_last),   32'(exp_q.size() == 1));
          check({tag, "_count"},  32'(o_count),  32'(pc));
        end else begin
          check({tag, "_extra_beat"}, 32'(o_valid), 0);
        end

        stall = 1'b0;
        case (mode)
          1: stall = ($urandom_range(0, 2) == 0);
          2: if (stall_left > 0) begin
               stall = 1'b1;
               stall_left--;
             end
          3: if (cyc == 0) begin
               i_start   = 1'b1;
               i_reglist = 16'h00F0;
               i_order   = ~order;
             end
          default: stall = 1'b0;
        endcase
        if (!stall && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          accepted++;
        end
        i_stall = stall;
        @(negedge clk);
      end
    end

    i_stall = 1'b0;
    i_start = 1'b0;
    if (!done_seen) begin
      check({tag, "_timeout"}, 1, 0);
      apply_reset();
    end else begin
      @(negedge clk);
      check({tag, "_post_done"}, 32'(o_done), 0);
      check({tag, "_post_busy"}, 32'(o_busy), 0);
    end
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    i_start   = 1'b0;
    i_reglist = 16'd0;
    i_order   = 1'b0;
    i_stall   = 1'b0;

    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    run_seq("asc_8011",  16'h8011, 1'b1, 0);
    run_seq("desc_8011", 16'h8011, 1'b0, 0);
    run_seq("stall_0006", 16'h0006, 1'b1, 2);
    run_seq("empty",     16'h0000, 1'b1, 0);
    run_seq("full_asc",  16'hFFFF, 1'b1, 0);
    run_seq("start_ign", 16'h8011, 1'b1, 3);

    // Asynchronous reset in the middle of a sequence, between edges.
    @(negedge clk);
    i_start   = 1'b1;
    i_reglist = 16'hFFFF;
    i_order   = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_valid_before_rst", 32'(o_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_done", 32'(o_done), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_rst");
    run_seq("single_0001", 16'h0001, 1'b1, 0);

    for (int n = 0; n < 200; n++) begin
      run_seq("rand", 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
